// File: rtl/fft_stage_sched.sv
// Radix-2 in-place FFT stage sequencer: walks every stage, issues butterfly operand
// addresses / twiddle index / bank over valid-ready, and drains each stage before the next.
module fft_stage_sched #(
    parameter int LOG2N   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_bf_valid,
    input  logic                     i_bf_ready,
    output logic [LOG2N-1:0]         o_addr_a,
    output logic [LOG2N-1:0]         o_addr_b,
    output logic [LOG2N-2:0]         o_tw_idx,
    output logic [$clog2(LOG2N)-1:0] o_stage,
    output logic                     o_bank,
    input  logic                     i_bf_done,
    output logic                     o_done
);
    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [KW-1:0] K_LAST  = {KW{1'b1}};
    localparam logic [SW-1:0] S_LAST  = SW'(LOG2N - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_NEXT,
        ST_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [KW-1:0]     r_k;
    logic [KW-1:0]     w_k_next;
    logic [SW-1:0]     r_stage;
    logic [SW-1:0]     w_stage_next;
    logic              r_bank;
    logic              w_bank_next;
    logic [OW-1:0]     r_out;
    logic [OW-1:0]     w_out_next;
    logic [LOG2N-1:0]  r_addr_a;
    logic [LOG2N-1:0]  r_addr_b;
    logic [KW-1:0]     r_tw_idx;

    logic              w_accept;
    logic              w_dec;
    logic [LOG2N-1:0]  w_kk;
    logic [LOG2N-1:0]  w_span;
    logic [LOG2N-1:0]  w_pos;
    logic [LOG2N-1:0]  w_addr_a;
    logic [LOG2N-1:0]  w_addr_b;
    logic [KW-1:0]     w_tw_idx;

    assign o_bf_valid = (r_state == ST_ISSUE) && (r_out < OUT_MAX);
    assign w_accept   = o_bf_valid && i_bf_ready;
    // A completion with nothing outstanding is stale (e.g. from before a reset) and dropped.
    assign w_dec      = i_bf_done && (r_out != '0);

    always_comb begin
        w_out_next = r_out;
        case ({w_accept, w_dec})
            2'b10:   w_out_next = r_out + OW'(1);
            2'b01:   w_out_next = r_out - OW'(1);
            default: w_out_next = r_out;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_stage_next = r_stage;
        w_bank_next  = r_bank;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_ISSUE;
                    w_k_next     = '0;
                    w_stage_next = '0;
                    w_bank_next  = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    w_k_next = r_k + KW'(1);
                    if (r_k == K_LAST) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Look at the post-edge count so the last write-back releases the stage at once.
                if (w_out_next == '0) begin
                    w_state_next = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_bank_next = ~r_bank;
                w_k_next    = '0;
                if (r_stage == S_LAST) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_stage_next = r_stage + SW'(1);
                    w_state_next = ST_ISSUE;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Operand addresses for the butterfly that will be presented next cycle.
    always_comb begin
        w_kk     = {1'b0, w_k_next};
        w_span   = LOG2N'(1) << w_stage_next;
        w_pos    = w_kk & (w_span - LOG2N'(1));
        w_addr_a = ((w_kk >> w_stage_next) << ({1'b0, w_stage_next} + (SW + 1)'(1))) | w_pos;
        w_addr_b = w_addr_a + w_span;
        w_tw_idx = KW'(w_pos << (S_LAST - w_stage_next));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_stage  <= '0;
            r_bank   <= 1'b0;
            r_out    <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_tw_idx <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_stage <= w_stage_next;
            r_bank  <= w_bank_next;
            r_out   <= w_out_next;
            if (w_state_next == ST_ISSUE) begin
                r_addr_a <= w_addr_a;
                r_addr_b <= w_addr_b;
                r_tw_idx <= w_tw_idx;
            end
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_FINISH);
    assign o_addr_a = r_addr_a;
    assign o_addr_b = r_addr_b;
    assign o_tw_idx = r_tw_idx;
    assign o_stage  = r_stage;
    assign o_bank   = r_bank;

endmodule

// File: tb/tb_fft_stage_sched.sv
// Self-checking bench for fft_stage_sched: in-order butterfly model, scheduled write-back
// responder, hand sequences for backpressure, stalls, reset abort and start filtering.
module tb_fft_stage_sched;
    localparam int LOG2N   = 4;
    localparam int MAX_OUT = 3;
    localparam int N       = 1 << LOG2N;
    localparam int HALF    = N / 2;
    localparam int SW      = $clog2(LOG2N);
    localparam int LAT     = 2;
    localparam int FULL_CYC = 1 + LOG2N * (HALF + LAT + 1) + 1;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_start;
    logic             i_bf_ready;
    logic             i_bf_done;
    logic             o_busy;
    logic             o_bf_valid;
    logic             o_done;
    logic             o_bank;
    logic [LOG2N-1:0] o_addr_a;
    logic [LOG2N-1:0] o_addr_b;
    logic [LOG2N-2:0] o_tw_idx;
    logic [SW-1:0]    o_stage;

    fft_stage_sched #(.LOG2N(LOG2N), .MAX_OUT(MAX_OUT)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .o_busy     (o_busy),
        .o_bf_valid (o_bf_valid),
        .i_bf_ready (i_bf_ready),
        .o_addr_a   (o_addr_a),
        .o_addr_b   (o_addr_b),
        .o_tw_idx   (o_tw_idx),
        .o_stage    (o_stage),
        .o_bank     (o_bank),
        .i_bf_done  (i_bf_done),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int s;
        int k;
        int a;
        int b;
        int tw;
    } bf_t;

    bf_t vec [8];
    int  bank_exp [LOG2N];
    bf_t exp_q [$];
    int  done_q [$];
    int  log_pk [LOG2N][HALF];
    int  log_bank [LOG2N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_out = 0;
    int n_acc = 0;
    int n_done = 0;
    int acc_base = 0;
    int done_base = 0;
    int t_start = 0;
    int manual_done = 0;
    bit ready_rand = 1'b0;
    bit ready_val = 1'b1;
    bit lat_rand = 1'b0;
    bit auto_done = 1'b1;
    bit log_en = 1'b0;

    function automatic logic [31:0] pk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] tw, input logic [31:0] s,
                                       input logic [31:0] bank);
        return (a << 12) | (b << 8) | (tw << 4) | (s << 1) | bank;
    endfunction

    function automatic logic [31:0] all_outputs();
        return 32'({o_busy, o_bf_valid, o_done, o_addr_a, o_addr_b, o_tw_idx, o_stage, o_bank});
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected issue order from the butterfly grouping: group g, position j within the group.
    task automatic load_model();
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < HALF; k++) begin
                bf_t e;
                int span;
                span = 1 << s;
                e.s  = s;
                e.k  = k;
                e.a  = (k / span) * 2 * span + (k % span);
                e.b  = e.a + span;
                e.tw = (k % span) * (HALF / span);
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock: check what the DUT presents now, advance, then drive the next cycle's inputs.
    task automatic step();
        bit acc;
        int dec;
        bf_t e;
        acc = i_rst_n && o_bf_valid && i_bf_ready;
        if (i_rst_n) begin
            if (o_bf_valid === 1'b1) chk("out_bound", 32'(model_out < MAX_OUT), 1);
            if (acc) begin
                if (exp_q.size() == 0) begin
                    chk("extra_accept", pk(o_addr_a, o_addr_b, o_tw_idx, o_stage, o_bank), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bf_s%0d_k%0d", e.s, e.k), pk(o_addr_a, o_addr_b, o_tw_idx, o_stage, o_bank),
                        pk(e.a, e.b, e.tw, e.s, e.s % 2));
                    if (log_en) begin
                        log_pk[e.s][e.k] = int'(pk(o_addr_a, o_addr_b, o_tw_idx, o_stage, o_bank));
                        if (e.k == 0) log_bank[e.s] = int'(o_bank);
                    end
                end
                n_acc++;
                done_q.push_back(cyc + (lat_rand ? int'($urandom_range(6, 1)) : LAT));
            end
            if (o_done === 1'b1) n_done++;
        end
        if (!i_rst_n) begin
            model_out = 0;
        end else begin
            dec = (i_bf_done && model_out > 0) ? 1 : 0;
            model_out = model_out + (acc ? 1 : 0) - dec;
        end
        @(posedge i_clk);
        #1;
        cyc++;
        i_start    = 1'b0;
        i_bf_ready = ready_rand ? ($urandom_range(3) != 0) : ready_val;
        i_bf_done  = 1'b0;
        if (done_q.size() > 0) begin
            if (auto_done ? (done_q[0] <= cyc) : (manual_done > 0)) begin
                i_bf_done = 1'b1;
                void'(done_q.pop_front());
                if (!auto_done) manual_done--;
            end
        end
    endtask

    task automatic start_xfer();
        load_model();
        acc_base  = n_acc;
        done_base = n_done;
        t_start   = cyc;
        i_start   = 1'b1;
        step();
    endtask

    task automatic finish_xfer(input string name, input int exp_cyc, input bit start_on_done);
        int budget;
        budget = 2000;
        while (o_done !== 1'b1 && budget > 0) begin
            chk("busy_during_xfer", 32'(o_busy), 1);
            step();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: o_done not seen, got accepts %0d required %0d", name, n_acc - acc_base, LOG2N * HALF);
        end else begin
            $display("xfer %s: accepts=%0d done_at_cycle=%0d", name, n_acc - acc_base, cyc - t_start + 1);
            chk({name, "_accepts"}, 32'(n_acc - acc_base), 32'(LOG2N * HALF));
            chk({name, "_model_left"}, 32'(exp_q.size()), 0);
            if (exp_cyc > 0) chk({name, "_done_cycle"}, 32'(cyc - t_start + 1), 32'(exp_cyc));
            if (start_on_done) i_start = 1'b1;
            step();
            chk({name, "_done_pulses"}, 32'(n_done - done_base), 1);
            chk({name, "_done_one_cycle"}, 32'(o_done), 0);
            chk({name, "_idle_after"}, 32'(o_busy), 0);
        end
    endtask

    initial begin
        vec = '{'{0, 3, 6, 7, 0}, '{1, 3, 5, 7, 4}, '{3, 5, 5, 13, 5}, '{2, 6, 10, 14, 4},
                '{0, 7, 14, 15, 0}, '{3, 0, 0, 8, 0}, '{1, 6, 12, 14, 0}, '{2, 3, 3, 7, 6}};
        bank_exp = '{0, 1, 0, 1};
        for (int s = 0; s < LOG2N; s++) begin
            log_bank[s] = -1;
            for (int k = 0; k < HALF; k++) log_pk[s][k] = -1;
        end

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_bf_ready = 1'b1;
        i_bf_done = 1'b0;
        repeat (3) step();
        chk("reset_outputs", all_outputs(), 0);
        i_rst_n = 1'b1;
        step();
        chk("idle_outputs", all_outputs(), 0);

        // Full transform at full throughput, plus no stall on simultaneous accept and done.
        log_en = 1'b1;
        start_xfer();
        repeat (3) step();
        chk("acc_done_same_cycle_valid", 32'(o_bf_valid), 1);
        step();
        chk("acc_done_no_stall", 32'(o_bf_valid), 1);
        finish_xfer("full", FULL_CYC, 1'b0);
        log_en = 1'b0;
        chk("bank_after_done", 32'(o_bank), 32'(LOG2N % 2));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("vec%0d_s%0d_k%0d", i, vec[i].s, vec[i].k), log_pk[vec[i].s][vec[i].k],
                pk(vec[i].a, vec[i].b, vec[i].tw, vec[i].s, vec[i].s % 2));
        end
        for (int s = 0; s < LOG2N; s++) chk($sformatf("bank_stage%0d", s), log_bank[s], bank_exp[s]);

        // Backpressure mid stage 1: request held stable for 5 cycles.
        start_xfer();
        for (int i = 0; i < 200 && (n_acc - acc_base) < HALF + 3; i++) step();
        chk("bp_reach_stage1", 32'(o_stage), 1);
        ready_val = 1'b0;
        step();
        begin
            logic [31:0] snap;
            snap = pk(o_addr_a, o_addr_b, o_tw_idx, o_stage, o_bank);
            for (int i = 0; i < 5; i++) begin
                chk("bp_valid_held", 32'(o_bf_valid), 1);
                chk("bp_request_held", pk(o_addr_a, o_addr_b, o_tw_idx, o_stage, o_bank), snap);
                if (i == 4) ready_val = 1'b1;
                step();
            end
        end
        finish_xfer("backpressure", FULL_CYC + 5, 1'b0);
        step();

        // Write-backs withheld: issue stops at MAX_OUT, one done frees exactly one slot.
        auto_done = 1'b0;
        start_xfer();
        repeat (8) step();
        chk("maxout_accepts", 32'(n_acc - acc_base), MAX_OUT);
        chk("maxout_valid_low", 32'(o_bf_valid), 0);
        manual_done = 1;
        repeat (4) step();
        chk("one_done_one_issue", 32'(n_acc - acc_base), MAX_OUT + 1);
        chk("one_done_valid_low", 32'(o_bf_valid), 0);
        auto_done = 1'b1;
        finish_xfer("withheld", -1, 1'b0);
        step();

        // Reset during stage 2 aborts without o_done; stale write-backs are ignored.
        start_xfer();
        for (int i = 0; i < 200 && (n_acc - acc_base) < 2 * HALF + 3; i++) step();
        chk("abort_reach_stage2", 32'(o_stage), 2);
        done_base = n_done;
        i_rst_n = 1'b0;
        step();
        chk("abort_outputs", all_outputs(), 0);
        i_rst_n = 1'b1;
        exp_q.delete();
        repeat (6) begin
            step();
            chk("abort_stays_idle", all_outputs(), 0);
        end
        chk("abort_no_done", 32'(n_done - done_base), 0);
        done_q.delete();
        start_xfer();
        finish_xfer("after_abort", FULL_CYC, 1'b0);

        // Start ignored while busy and on the o_done cycle; taken one cycle later.
        start_xfer();
        repeat (5) step();
        i_start = 1'b1;
        step();
        finish_xfer("start_while_busy", FULL_CYC, 1'b1);
        start_xfer();
        chk("start_from_idle_taken", 32'(o_busy), 1);
        finish_xfer("restart", FULL_CYC, 1'b0);

        // Randomized ready and write-back latency.
        ready_rand = 1'b1;
        lat_rand   = 1'b1;
        repeat (3) begin
            start_xfer();
            finish_xfer("random", -1, 1'b0);
        end
        ready_rand = 1'b0;
        lat_rand   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Sequences a radix-2 in-place FFT across all stages for the audio spectral-flux front end.
- Generates the butterfly operand addresses, twiddle index and ping-pong bank select for each butterfly, then issues them to the butterfly/memory datapath over a valid/ready handshake.
- Tracks outstanding butterflies and drains each stage before starting the next.
- Sits between the frame-level controller (start/done) and the butterfly unit plus sample RAM.

Parameters:
- LOG2N, 8, log2 of FFT length (N = 2^LOG2N points, N/2 butterflies per stage).
- MAX_OUT, 4, maximum butterflies issued but not yet completed (range 1..15).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-cycle pulse that begins a full transform; ignored unless in IDLE.
- o_busy  out  1  high in every state except IDLE.
- o_bf_valid  out  1  butterfly request valid.
- i_bf_ready  in  1  butterfly unit accepts the request this cycle.
- o_addr_a  out  LOG2N  upper-wing operand address.
- o_addr_b  out  LOG2N  lower-wing operand address.
- o_tw_idx  out  LOG2N-1  twiddle ROM index.
- o_stage  out  $clog2(LOG2N)  current stage number.
- o_bank  out  1  read bank; the write bank is ~o_bank.
- i_bf_done  in  1  one-cycle pulse per completed butterfly write-back.
- o_done  out  1  one-cycle pulse when the transform is complete.

Behaviour:
- Reset: synchronous, sampled on the rising edge of i_clk while i_rst_n=0. All outputs are 0, state=IDLE, counters and outstanding count are 0. Reset mid-transform aborts immediately with no o_done; done pulses still in flight after reset are ignored.
- States: IDLE, ISSUE, DRAIN, NEXT, FINISH.
- IDLE: on i_start go to ISSUE with stage s=0, butterfly index k=0, o_bank=0.
- Address rules for stage s and index k (0 <= k < N/2):
  - span = 2^s, pos = k & (span-1).
  - addr_a = ((k>>s)<<(s+1)) | pos.
  - addr_b = addr_a + span.
  - tw_idx = pos << (LOG2N-1-s).
  - All values are registered and consistent with o_bf_valid in the same cycle.
- ISSUE:
  - o_bf_valid=1 whenever outstanding < MAX_OUT; otherwise o_bf_valid=0 (stall).
  - Outputs are held stable while valid=1 and ready=0.
  - On accept (valid & ready), k increments and the next request may issue in the following cycle, giving 1 request per cycle at full throughput.
  - After accepting k=N/2-1, go to DRAIN.
- Outstanding counter:
  - +1 on accept, -1 on i_bf_done; both in the same cycle leaves it unchanged.
  - i_bf_done when outstanding=0 is ignored (no underflow).
  - Never exceeds MAX_OUT.
- DRAIN: o_bf_valid=0; wait until outstanding=0, then go to NEXT.
- NEXT (one cycle): toggle o_bank and increment s. If s was LOG2N-1, go to FINISH; otherwise clear k and go to ISSUE.
- FINISH: o_done=1 for exactly one cycle, then IDLE. o_stage and o_bank keep their last values in IDLE until the next start.
- i_start while busy is ignored. i_start in the same cycle as o_done is also ignored; a new start is taken only from IDLE.
- Cycle count with ready=1 and done returning L cycles after accept (L < MAX_OUT): per stage N/2 issue cycles + L drain + 1 NEXT; plus 1 entry cycle and 1 FINISH cycle.

Test Plan:
1. LOG2N=4, ready=1, done 2 cycles after each accept, pulse start -> 32 accepts total. Stage 0 k=3 gives a=6, b=7, tw=0. Stage 1 k=3 gives a=5, b=7, tw=4. Stage 3 k=5 gives a=5, b=13, tw=5. o_bank sequence is 0,1,0,1. A single o_done arrives at cycle 1 + 4*(8+2+1) + 1 = 46 after start.
2. Backpressure: hold ready=0 for 5 cycles mid-stage -> addresses and valid stay stable, and no k is skipped or duplicated.
3. MAX_OUT=2, withhold i_bf_done -> valid drops after 2 accepts. A single done pulse re-enables exactly one issue.
4. Simultaneous accept and done with outstanding=MAX_OUT-1 -> outstanding stays unchanged and issue continues without a stall cycle.
5. Assert reset during stage 2 -> the next cycle shows all outputs 0 and IDLE, with no o_done. A following start runs a full transform correctly.
6. Pulse i_start during ISSUE and again on the o_done cycle -> both are ignored; a start one cycle later in IDLE begins a new transform.
